fft_4: RTL and testbench



---
 rtl/fft_4_pkg.sv | 53 +++++
 rtl/fft_4_if.sv | 23 ++
 rtl/fft_4_bfly.sv | 31 +++
 rtl/fft_4.sv | 109 ++++++++++
 tb/tb_fft_4.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_4_pkg.sv
// fft_4_pkg: shared types and helpers for the 4-point FFT engine.
//   WIDTH      : component width of input samples and output bins
//   EXT_W      : internal width (WIDTH+2), enough for two butterfly stages
//   cplx_t     : signed complex sample at WIDTH bits
//   cplx_ext_t : signed complex value at EXT_W bits
//   to_ext     : sign-extends a WIDTH-bit re/im pair into cplx_ext_t
//   sat        : clamps an EXT_W-bit value into the WIDTH-bit signed range
//   asr1       : arithmetic shift right by one (rounds toward -inf)
package fft_4_pkg;

  localparam int WIDTH = 16;
  localparam int EXT_W = WIDTH + 2;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [EXT_W-1:0] re;
    logic signed [EXT_W-1:0] im;
  } cplx_ext_t;

  function automatic cplx_ext_t to_ext(input logic signed [WIDTH-1:0] re,
                                       input logic signed [WIDTH-1:0] im);
    cplx_ext_t r;
    r.re = {{2{re[WIDTH-1]}}, re};
    r.im = {{2{im[WIDTH-1]}}, im};
    return r;
  endfunction

  // Value fits when the top three bits are all equal (pure sign extension).
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [EXT_W-1:0] v);
    if (v[EXT_W-1:WIDTH-1] == 3'b000 || v[EXT_W-1:WIDTH-1] == 3'b111)
      return v[WIDTH-1:0];
    else if (v[EXT_W-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic logic signed [EXT_W-1:0] asr1(input logic signed [EXT_W-1:0] v);
    return v >>> 1;
  endfunction

  function automatic cplx_ext_t cplx_asr1(input cplx_ext_t c);
    cplx_ext_t r;
    r.re = asr1(c.re);
    r.im = asr1(c.im);
    return r;
  endfunction

endpackage

// File: rtl/fft_4_if.sv
// fft_4_if: sample/bin bundle for the 4-point FFT engine.
//   in_valid, x0..x3 re/im : time-domain sample set (master -> slave)
//   out_valid, y0..y3 re/im: frequency-domain bins (slave -> master)
interface fft_4_if;
  import fft_4_pkg::*;

  logic                    in_valid;
  logic signed [WIDTH-1:0] x0_re, x0_im, x1_re, x1_im;
  logic signed [WIDTH-1:0] x2_re, x2_im, x3_re, x3_im;
  logic                    out_valid;
  logic signed [WIDTH-1:0] y0_re, y0_im, y1_re, y1_im;
  logic signed [WIDTH-1:0] y2_re, y2_im, y3_re, y3_im;

  modport master (
    output in_valid, x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
    input  out_valid, y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im
  );

  modport slave (
    input  in_valid, x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
    output out_valid, y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im
  );
endinterface

// File: rtl/fft_4_bfly.sv
// fft_4_bfly: combinational radix-2 complex butterfly.
//   a, b      : inputs (EXT_W-bit complex)
//   sum, diff : a + b' and a - b', where b' = -j*b when ROT_NJ = 1, else b
// Operands arrive already sign-extended, so sums cannot wrap.
module fft_4_bfly
  import fft_4_pkg::*;
#(
  parameter bit ROT_NJ = 1'b0
) (
  input  cplx_ext_t a,
  input  cplx_ext_t b,
  output cplx_ext_t sum,
  output cplx_ext_t diff
);

  cplx_ext_t b_rot;

  always_comb begin
    b_rot = b;
    // -j * (re + j im) = im - j re : swap and negate, no multiplier
    if (ROT_NJ) begin
      b_rot.re = b.im;
      b_rot.im = -b.re;
    end
    sum.re  = a.re + b_rot.re;
    sum.im  = a.im + b_rot.im;
    diff.re = a.re - b_rot.re;
    diff.im = a.im - b_rot.im;
  end

endmodule

// File: rtl/fft_4.sv
// fft_4: 4-point complex FFT, two registered butterfly stages, one
// transform per clock, latency two cycles, no backpressure.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, flushes both stages
//   bus : fft_4_if.slave (in_valid/x0..x3 in, out_valid/y0..y3 out)
// Build option FFT4_SCALE_EN: when defined every stage result is shifted
// right by one (outputs = X[k]/4); otherwise outputs are saturated X[k].
module fft_4
  import fft_4_pkg::*;
(
  input logic   clk,
  input logic   rst,
  fft_4_if.slave bus
);

  cplx_ext_t xe [4];
  cplx_ext_t a0, a1, b0, b1;
  cplx_ext_t a0_d, a1_d, b0_d, b1_d;
  cplx_ext_t a0_q, a1_q, b0_q, b1_q;
  cplx_ext_t y0_e, y1_e, y2_e, y3_e;
  cplx_t     y_d [4];
  logic      v1_q;

  always_comb begin
    xe[0] = to_ext(bus.x0_re, bus.x0_im);
    xe[1] = to_ext(bus.x1_re, bus.x1_im);
    xe[2] = to_ext(bus.x2_re, bus.x2_im);
    xe[3] = to_ext(bus.x3_re, bus.x3_im);
  end

  fft_4_bfly #(.ROT_NJ(1'b0)) u_s1_even (.a(xe[0]), .b(xe[2]), .sum(a0), .diff(b0));
  fft_4_bfly #(.ROT_NJ(1'b0)) u_s1_odd  (.a(xe[1]), .b(xe[3]), .sum(a1), .diff(b1));

  always_comb begin
`ifdef FFT4_SCALE_EN
    a0_d = cplx_asr1(a0);
    a1_d = cplx_asr1(a1);
    b0_d = cplx_asr1(b0);
    b1_d = cplx_asr1(b1);
`else
    a0_d = a0;
    a1_d = a1;
    b0_d = b0;
    b1_d = b1;
`endif
  end

  fft_4_bfly #(.ROT_NJ(1'b0)) u_s2_even (.a(a0_q), .b(a1_q), .sum(y0_e), .diff(y2_e));
  fft_4_bfly #(.ROT_NJ(1'b1)) u_s2_odd  (.a(b0_q), .b(b1_q), .sum(y1_e), .diff(y3_e));

  // With scaling the shifted value always fits, so sat() is a pure truncation.
  function automatic cplx_t finish(input cplx_ext_t v);
    cplx_t r;
`ifdef FFT4_SCALE_EN
    r.re = sat(asr1(v.re));
    r.im = sat(asr1(v.im));
`else
    r.re = sat(v.re);
    r.im = sat(v.im);
`endif
    return r;
  endfunction

  always_comb begin
    y_d[0] = finish(y0_e);
    y_d[1] = finish(y1_e);
    y_d[2] = finish(y2_e);
    y_d[3] = finish(y3_e);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q          <= 1'b0;
      a0_q          <= '0;
      a1_q          <= '0;
      b0_q          <= '0;
      b1_q          <= '0;
      bus.out_valid <= 1'b0;
      bus.y0_re     <= '0;
      bus.y0_im     <= '0;
      bus.y1_re     <= '0;
      bus.y1_im     <= '0;
      bus.y2_re     <= '0;
      bus.y2_im     <= '0;
      bus.y3_re     <= '0;
      bus.y3_im     <= '0;
    end else begin
      v1_q          <= bus.in_valid;
      bus.out_valid <= v1_q;
      if (bus.in_valid) begin
        a0_q <= a0_d;
        a1_q <= a1_d;
        b0_q <= b0_d;
        b1_q <= b1_d;
      end
      if (v1_q) begin
        bus.y0_re <= y_d[0].re;
        bus.y0_im <= y_d[0].im;
        bus.y1_re <= y_d[1].re;
        bus.y1_im <= y_d[1].im;
        bus.y2_re <= y_d[2].re;
        bus.y2_im <= y_d[2].im;
        bus.y3_re <= y_d[3].re;
        bus.y3_im <= y_d[3].im;
      end
    end
  end

endmodule

// File: tb/tb_fft_4.sv
// tb_fft_4: table-driven and random-stream bench for fft_4 with a queue
// scoreboard. Works in either build (FFT4_SCALE_EN defined or not).
module tb_fft_4;
  import fft_4_pkg::*;

  // index 2k = bin/sample k real, 2k+1 = imaginary
  typedef logic [7:0][15:0] vec8_t;
  typedef struct packed { vec8_t y; int cyc; } exp_t;
  typedef struct packed { vec8_t x; vec8_t y_unsc; vec8_t y_sc; } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  exp_t  q[$];
  vec8_t last_y = '0;
  int    cyc = 0;
  int    n_pass = 0;
  int    n_total = 0;
  vec_t  vecs[6];

  always #5 clk = ~clk;

  fft_4_if bus();
  fft_4 dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic string bin_name(input int i);
    case (i)
      0: return "y0_re";
      1: return "y0_im";
      2: return "y1_re";
      3: return "y1_im";
      4: return "y2_re";
      5: return "y2_im";
      6: return "y3_re";
      default: return "y3_im";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: the two butterfly stages written directly on integers.
  function automatic vec8_t model(input vec8_t x);
    int xr[4], xi[4], ar[2], ai[2], br[2], bi[2], yr[4], yi[4];
    vec8_t r;
    for (int n = 0; n < 4; n++) begin
      xr[n] = int'($signed(x[2*n]));
      xi[n] = int'($signed(x[2*n+1]));
    end
    for (int p = 0; p < 2; p++) begin
      ar[p] = xr[p] + xr[p+2];
      ai[p] = xi[p] + xi[p+2];
      br[p] = xr[p] - xr[p+2];
      bi[p] = xi[p] - xi[p+2];
`ifdef FFT4_SCALE_EN
      ar[p] = ar[p] >>> 1;
      ai[p] = ai[p] >>> 1;
      br[p] = br[p] >>> 1;
      bi[p] = bi[p] >>> 1;
`endif
    end
    yr[0] = ar[0] + ar[1];  yi[0] = ai[0] + ai[1];
    yr[2] = ar[0] - ar[1];  yi[2] = ai[0] - ai[1];
    yr[1] = br[0] + bi[1];  yi[1] = bi[0] - br[1];
    yr[3] = br[0] - bi[1];  yi[3] = bi[0] + br[1];
    for (int k = 0; k < 4; k++) begin
`ifdef FFT4_SCALE_EN
      yr[k] = yr[k] >>> 1;
      yi[k] = yi[k] >>> 1;
`endif
      r[2*k]   = 16'(clamp16(yr[k]));
      r[2*k+1] = 16'(clamp16(yi[k]));
    end
    return r;
  endfunction

  function automatic vec8_t sample_y();
    vec8_t r;
    r[0] = bus.y0_re; r[1] = bus.y0_im; r[2] = bus.y1_re; r[3] = bus.y1_im;
    r[4] = bus.y2_re; r[5] = bus.y2_im; r[6] = bus.y3_re; r[7] = bus.y3_im;
    return r;
  endfunction

  task automatic put_x(input vec8_t x);
    bus.x0_re = x[0]; bus.x0_im = x[1]; bus.x1_re = x[2]; bus.x1_im = x[3];
    bus.x2_re = x[4]; bus.x2_im = x[5]; bus.x3_re = x[6]; bus.x3_im = x[7];
  endtask

  function automatic vec8_t rand_vec();
    vec8_t r;
    for (int i = 0; i < 8; i++) r[i] = 16'($urandom);
    return r;
  endfunction

  task automatic send(input vec8_t x, input vec8_t y);
    exp_t e;
    @(posedge clk);
    #1;
    put_x(x);
    bus.in_valid = 1'b1;
    e.y   = y;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  // Junk on x while idle: registers must ignore it.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      put_x(rand_vec());
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      last_y = '0;
    end
  end

  always @(negedge clk) begin
    vec8_t act;
    exp_t  e;
    act = sample_y();
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.cyc, 2);
        for (int k = 0; k < 8; k++)
          chk(bin_name(k), int'($signed(act[k])), int'($signed(e.y[k])));
        last_y = e.y;
      end
    end else begin
      for (int k = 0; k < 8; k++)
        chk({"hold_", bin_name(k)}, int'($signed(act[k])), int'($signed(last_y[k])));
    end
  end

  initial begin
    vec8_t a, b, y_sel;

    for (int i = 0; i < 6; i++) vecs[i] = '0;
    // impulse
    vecs[1].x[0] = 16'd100;
    for (int k = 0; k < 4; k++) begin
      vecs[1].y_unsc[2*k] = 16'd100;
      vecs[1].y_sc[2*k]   = 16'd25;
    end
    // DC
    for (int k = 0; k < 4; k++) vecs[2].x[2*k] = 16'd1000;
    vecs[2].y_unsc[0] = 16'd4000;
    vecs[2].y_sc[0]   = 16'd1000;
    // quarter-rate tone
    vecs[3].x[2] = 16'd1000;
    vecs[3].x[6] = 16'(-1000);
    vecs[3].y_unsc[3] = 16'(-2000);
    vecs[3].y_unsc[7] = 16'd2000;
    vecs[3].y_sc[3]   = 16'(-500);
    vecs[3].y_sc[7]   = 16'd500;
    // positive and negative full scale
    for (int k = 0; k < 4; k++) begin
      vecs[4].x[2*k] = 16'h7FFF;
      vecs[5].x[2*k] = 16'h8000;
    end
    vecs[4].y_unsc[0] = 16'h7FFF;
    vecs[4].y_sc[0]   = 16'h7FFF;
    vecs[5].y_unsc[0] = 16'h8000;
    vecs[5].y_sc[0]   = 16'h8000;

    bus.in_valid = 1'b0;
    put_x('0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 6; i++) begin
`ifdef FFT4_SCALE_EN
      y_sel = vecs[i].y_sc;
`else
      y_sel = vecs[i].y_unsc;
`endif
      send(vecs[i].x, y_sel);
    end
    idle(3);

    for (int i = 0; i < 5; i++) begin
      a = rand_vec();
      send(a, model(a));
    end
    idle(3);

    // two sets in flight when reset is sampled: neither may emerge
    a = rand_vec();
    b = rand_vec();
    send(a, model(a));
    @(posedge clk);
    #1;
    put_x(b);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    idle(4);

    a = rand_vec();
    send(a, model(a));
    idle(4);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
